// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: button/mode front end for the PWM generator.
// Debounces up/down/freq buttons and keeps the duty code (0..10) and the
// frequency code (0..3). Define PWM_DUTY_CTRL_RAMP_EN to add the auto-ramp
// ("breathing") FSM driven by i_mode; without it i_mode is ignored.
module pwm_duty_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RAMP_DIV        = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_up,
  input  logic       i_btn_dn,
  input  logic       i_btn_freq,
  input  logic       i_mode,
  output logic [3:0] o_duty,
  output logic [1:0] o_freq,
  output logic       o_change
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      DUTY_MAX = 4'd10;

  // Button lanes: [0] up, [1] down, [2] freq
  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync2_q, lvl_q, lvl_prev_q, press_q;
  logic [CW-1:0] cnt_q [3];

  logic [3:0] duty_q, duty_man_d;
  logic [1:0] freq_q, freq_d;
  logic       change_q;
  logic       man_up, man_dn;

  assign btn_raw = {i_btn_freq, i_btn_dn, i_btn_up};

  // Synchronize, debounce and rising-edge detect every button
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      press_q    <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl_q;
      press_q    <= lvl_q & ~lvl_prev_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == lvl_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          lvl_q[i] <= ~lvl_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Manual step requests; simultaneous up+down cancel, limits are no-ops
  always_comb begin
    man_up     = press_q[0] & ~press_q[1] & (duty_q != DUTY_MAX);
    man_dn     = press_q[1] & ~press_q[0] & (duty_q != 4'd0);
    duty_man_d = duty_q;
    if (man_up) duty_man_d = duty_q + 4'd1;
    if (man_dn) duty_man_d = duty_q - 4'd1;
    freq_d     = freq_q + {1'b0, press_q[2]};
  end

`ifdef PWM_DUTY_CTRL_RAMP_EN
  localparam int            PW       = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {MANUAL, RAMP_UP, RAMP_DN} state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic          mode_s1_q, mode_s2_q, mode_prev_q;
  logic          tick;

  assign tick = (presc_q == PRE_LAST);

  // Mode level synchronizer plus previous value for rise detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_s1_q   <= 1'b0;
      mode_s2_q   <= 1'b0;
      mode_prev_q <= 1'b0;
    end else begin
      mode_s1_q   <= i_mode;
      mode_s2_q   <= mode_s1_q;
      mode_prev_q <= mode_s2_q;
    end
  end

  // Duty/freq FSM: manual stepping or triangular ramp on the prescaled tick
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= MANUAL;
      presc_q  <= '0;
      duty_q   <= '0;
      freq_q   <= '0;
      change_q <= 1'b0;
    end else begin
      freq_q   <= freq_d;
      change_q <= press_q[2];
      case (state_q)
        MANUAL: begin
          duty_q   <= duty_man_d;
          change_q <= man_up | man_dn | press_q[2];
          if (mode_s2_q && !mode_prev_q) begin
            // Direction chosen from the post-step duty so a same-cycle
            // press to 10 cannot push the ramp past the limit
            state_q <= (duty_man_d < DUTY_MAX) ? RAMP_UP : RAMP_DN;
            presc_q <= '0;
          end
        end
        RAMP_UP, RAMP_DN: begin
          if (!mode_s2_q) begin
            state_q <= MANUAL;
            presc_q <= '0;
          end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (tick) begin
              change_q <= 1'b1;
              if (state_q == RAMP_UP) begin
                duty_q <= duty_q + 4'd1;
                if (duty_q == DUTY_MAX - 4'd1) state_q <= RAMP_DN;
              end else begin
                duty_q <= duty_q - 4'd1;
                if (duty_q == 4'd1) state_q <= RAMP_UP;
              end
            end
          end
        end
        default: state_q <= MANUAL;
      endcase
    end
  end
`else
  localparam int unused_ramp_div = RAMP_DIV;
  logic          unused_mode;
  assign unused_mode = i_mode;

  // Manual-only duty/freq registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      duty_q   <= '0;
      freq_q   <= '0;
      change_q <= 1'b0;
    end else begin
      duty_q   <= duty_man_d;
      freq_q   <= freq_d;
      change_q <= man_up | man_dn | press_q[2];
    end
  end
`endif

  assign o_duty   = duty_q;
  assign o_freq   = freq_q;
  assign o_change = change_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Scoreboard bench for pwm_duty_ctrl (DEBOUNCE_CYCLES=4, RAMP_DIV=8).
module tb_pwm_duty_ctrl;
  localparam int DB  = 4;
  localparam int RD  = 8;
  localparam int LAT = DB + 3;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_btn_up = 1'b0, i_btn_dn = 1'b0, i_btn_freq = 1'b0, i_mode = 1'b0;
  logic [3:0] o_duty;
  logic [1:0] o_freq;
  logic       o_change;

  pwm_duty_ctrl #(.DEBOUNCE_CYCLES(DB), .RAMP_DIV(RD)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn_up(i_btn_up), .i_btn_dn(i_btn_dn),
    .i_btn_freq(i_btn_freq), .i_mode(i_mode),
    .o_duty(o_duty), .o_freq(o_freq), .o_change(o_change)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  typedef struct {int cyc; int duty; int freq;} exp_t;
  exp_t q[$];
  int m_duty = 0, m_freq = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int at, input int d, input int f);
    exp_t e;
    e.cyc = at; e.duty = d; e.freq = f;
    q.push_back(e);
  endtask

  // Drive a button combination, predict the outcome, hold, release, settle
  task automatic press(input bit u, input bit d, input bit f, input int hold);
    int nd, nf;
    @(negedge i_clk);
    i_btn_up = u; i_btn_dn = d; i_btn_freq = f;
    nd = m_duty;
    if (u && !d && nd < 10) nd++;
    if (d && !u && nd > 0) nd--;
    nf = f ? (m_freq + 1) % 4 : m_freq;
    if (nd != m_duty || nf != m_freq) push_exp(cyc + 1 + LAT, nd, nf);
    m_duty = nd; m_freq = nf;
    repeat (hold) @(negedge i_clk);
    i_btn_up = 1'b0; i_btn_dn = 1'b0; i_btn_freq = 1'b0;
    repeat (DB + 8) @(negedge i_clk);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge i_clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  // Output monitor: every o_change pulse must match the head of the scoreboard
  exp_t mon_e;
  always @(negedge i_clk) begin
    if (!i_rst) begin
      chk("duty_range", int'(o_duty <= 4'd10), 1);
      if (q.size() != 0 && cyc > q[0].cyc) begin
        mon_e = q.pop_front();
        chk("missed_change", cyc, mon_e.cyc);
      end
      if (o_change) begin
        if (q.size() == 0) chk("unexpected_change", 1, 0);
        else begin
          mon_e = q.pop_front();
          chk("change_cyc", cyc, mon_e.cyc);
          chk("duty", int'(o_duty), mon_e.duty);
          chk("freq", int'(o_freq), mon_e.freq);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_duty", int'(o_duty), 0);
    chk("rst_freq", int'(o_freq), 0);
    chk("rst_change", int'(o_change), 0);
    i_rst = 1'b0;
    repeat (20) @(negedge i_clk);
    chk("idle_duty", int'(o_duty), 0);
    chk("idle_freq", int'(o_freq), 0);

    // Long hold gives exactly one step
    press(1, 0, 0, 12);
    wait_drain(50);
    chk("hold_one_step", int'(o_duty), 1);

    // Saturate at 10; the 11th press predicts no change
    for (int i = 0; i < 11; i++) press(1, 0, 0, 6);
    wait_drain(50);
    chk("sat_high", int'(o_duty), 10);

    for (int i = 0; i < 5; i++) press(0, 1, 0, 6);
    wait_drain(50);
    chk("down_to_5", int'(o_duty), 5);

    // 3-cycle glitch must be rejected
    @(negedge i_clk); i_btn_dn = 1'b1;
    repeat (3) @(negedge i_clk); i_btn_dn = 1'b0;
    repeat (15) @(negedge i_clk);
    chk("glitch_reject", int'(o_duty), 5);

    press(0, 1, 0, 6);
    press(1, 1, 0, 6);
    wait_drain(50);
    chk("up_dn_cancel", int'(o_duty), 4);

    for (int i = 0; i < 4; i++) begin
      press(0, 0, 1, 6);
      wait_drain(50);
      chk("freq_seq", int'(o_freq), (i + 1) % 4);
    end

    // Duty and freq in the same cycle: one pulse covers both
    press(1, 0, 1, 6);
    wait_drain(50);
    chk("combo_duty", int'(o_duty), 5);
    chk("combo_freq", int'(o_freq), 1);

`ifdef PWM_DUTY_CTRL_RAMP_EN
    for (int i = 0; i < 3; i++) press(1, 0, 0, 6);
    wait_drain(50);
    chk("pre_ramp", int'(o_duty), 8);

    begin
      int base, d;
      bit up;
      @(negedge i_clk);
      i_mode = 1'b1;
      base = cyc + 1;
      d = m_duty; up = 1'b1;
      for (int k = 0; k < 14; k++) begin
        d = up ? d + 1 : d - 1;
        push_exp(base + 10 + RD * k, d, m_freq);
        if (d == 10) up = 1'b0;
        if (d == 0)  up = 1'b1;
      end
      m_duty = d;
      repeat (12) @(negedge i_clk);
      i_btn_up = 1'b1;
      repeat (8) @(negedge i_clk);
      i_btn_up = 1'b0;
      wait_drain(200);
      i_mode = 1'b0;
      repeat (30) @(negedge i_clk);
      chk("ramp_exit_hold", int'(o_duty), 2);

      // Reset in the middle of a ramp
      @(negedge i_clk);
      i_mode = 1'b1;
      base = cyc + 1;
      for (int k = 0; k < 4; k++) push_exp(base + 10 + RD * k, 3 + k, m_freq);
      wait_drain(100);
      chk("ramp_at_6", int'(o_duty), 6);
      i_rst = 1'b1;
      q.delete();
      m_duty = 0; m_freq = 0;
      @(negedge i_clk);
      chk("midramp_rst_duty", int'(o_duty), 0);
      chk("midramp_rst_freq", int'(o_freq), 0);
      i_mode = 1'b0;
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      repeat (40) @(negedge i_clk);
      chk("post_rst_no_ramp", int'(o_duty), 0);
    end
`else
    @(negedge i_clk); i_mode = 1'b1;
    repeat (30) @(negedge i_clk);
    chk("mode_ignored", int'(o_duty), 5);
    i_mode = 1'b0;
`endif

    // Reset mid-debounce with the button held through reset release
    @(negedge i_clk); i_btn_up = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    q.delete();
    m_duty = 0; m_freq = 0;
    repeat (3) @(negedge i_clk);
    chk("midbounce_rst", int'(o_duty), 0);
    i_rst = 1'b0;
    push_exp(cyc + 1 + LAT, 1, 0);
    m_duty = 1;
    repeat (10) @(negedge i_clk);
    i_btn_up = 1'b0;
    repeat (12) @(negedge i_clk);
    wait_drain(30);
    chk("held_thru_rst", int'(o_duty), 1);

    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ctrl.md
# pwm_duty_ctrl

User-control front end for the PWM generator: debounces three push-buttons and a mode switch, and maintains the 4-bit duty code (0–10) and 2-bit frequency code (0–3) that drive the generator's duty and frequency inputs. An optional auto-ramp ("breathing") mode sweeps the duty code up and down on a prescaled tick. It sits directly upstream of the PWM generator, and its outputs connect straight to that generator's i_duty / i_freq.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a new button level (≥2).
- RAMP_DIV, 64: clock cycles per duty step in ramp mode (≥2).
- i_clk  input  1  clock.
- i_rst  input  1  reset, synchronous, active-high.
- i_btn_up  input  1  async button, duty +1.
- i_btn_dn  input  1  async button, duty −1.
- i_btn_freq  input  1  async button, frequency code +1 (wrapping).
- i_mode  input  1  async level, 1 = ramp mode (effective only with the ramp macro).
- o_duty  output  4  duty code 0..10, registered.
- o_freq  output  2  frequency code 0..3, registered.
- o_change  output  1  one-cycle pulse on any change of o_duty or o_freq.

## Operation
- Every async input passes through a 2-flop synchronizer. i_mode is synchronized only, not debounced.
- Debounce, per button:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - The counter clears whenever the synced sample equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES−1 while still differing, the debounced level toggles on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never toggles the level.
- Press event: the rising edge of a debounced level, detected against its previous-cycle value. It produces one internal press pulse. Releases produce nothing.
- Manual mode (state MANUAL):
  - Up press: o_duty = min(o_duty+1, 10).
  - Down press: o_duty = max(o_duty−1, 0).
  - Up and down press in the same cycle: no duty change.
  - A press at a limit (up at 10, down at 0) is a no-op and gives no o_change.
- Frequency press: o_freq increments, wrapping 3→0, in every mode. It is independent of, and may coincide with, a duty update; one o_change pulse covers both.
- o_duty never leaves 0..10.

## Timing
- Reset values: o_duty=0, o_freq=0, o_change=0. Synchronizers, debounced levels, counters and prescaler = 0. State = MANUAL.
- Button latency: a level first sampled at edge N updates o_duty/o_freq at edge N+DEBOUNCE_CYCLES+3, with o_change high for exactly that cycle.
- A held button gives exactly one step. There is no auto-repeat.
- Reset asserted mid-debounce or mid-ramp clears everything on the next edge.
- A button held through reset release produces a press once debounced.

## Configuration
- Macro PWM_DUTY_CTRL_RAMP_EN.
- Defined: adds the ramp FSM.
  - States: MANUAL, RAMP_UP, RAMP_DN.
  - Synced i_mode rising while in MANUAL: go to RAMP_UP if o_duty<10, else RAMP_DN. The prescaler clears.
  - Prescaler width is clog2(RAMP_DIV). It counts 0..RAMP_DIV−1; the tick occurs at RAMP_DIV−1.
  - On tick in RAMP_UP: duty+1. On the edge duty becomes 10, switch to RAMP_DN.
  - On tick in RAMP_DN: duty−1. On the edge duty becomes 0, switch to RAMP_UP.
  - Every ramp step pulses o_change.
  - Up/down presses are ignored in ramp states.
  - Synced i_mode low: return to MANUAL on the next edge. o_duty holds its value and the prescaler clears.
- Undefined: i_mode is ignored, the state is permanently MANUAL, and no prescaler is built.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and RAMP_DIV=8.
- Reset, then idle 20 cycles -> o_duty=0, o_freq=0, o_change never asserted.
- i_btn_up held 12 cycles -> o_duty=1 exactly 7 edges after first sample, one o_change pulse; 11 further presses -> o_duty saturates at 10, with no o_change on the 11th.
- 3-cycle glitch on i_btn_dn with o_duty=5 -> o_duty stays 5, no o_change.
- Up and down presses debounced in the same cycle with o_duty=4 -> o_duty stays 4. Four freq presses -> o_freq sequence 1,2,3,0.
- (macro defined) o_duty=8, i_mode=1 -> duty 9, 10, 9, 8… stepping every 8 cycles, turning at 10 and 0. Up presses during the ramp are ignored.
- (macro defined) i_rst asserted mid-ramp at duty=6 -> next edge o_duty=0, state MANUAL. With i_mode=0 after reset, no further steps.
